// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OpMultu = 2'b00,
    OpMult  = 2'b01,
    OpDivu  = 2'b10,
    OpDiv   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } muldiv_state_t;

  function automatic logic op_is_div(muldiv_op_t op);
    return (op == OpDivu) || (op == OpDiv);
  endfunction

  function automatic logic op_is_signed(muldiv_op_t op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final result shaping: sign correction of magnitude results and divide-by-zero override.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  muldiv_op_t           op,
  input  logic [2*WIDTH-1:0]   raw,
  input  logic                 neg_res,
  input  logic                 neg_rem,
  input  logic                 div_zero,
  output logic [WIDTH-1:0]     hi_res,
  output logic [WIDTH-1:0]     lo_res
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    prod   = neg_res ? (~raw + 1'b1) : raw;
    quot   = neg_res ? (~raw[WIDTH-1:0] + 1'b1) : raw[WIDTH-1:0];
    // With a zero divisor the remainder is the dividend magnitude, so re-signing yields srca.
    rem    = neg_rem ? (~raw[2*WIDTH-1:WIDTH] + 1'b1) : raw[2*WIDTH-1:WIDTH];
    case (op)
      OpMultu, OpMult: begin
        hi_res = prod[2*WIDTH-1:WIDTH];
        lo_res = prod[WIDTH-1:0];
      end
      default: begin
        hi_res = rem;
        lo_res = div_zero ? '1 : quot;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_in, op_q;
  logic [CNTW-1:0]    cnt_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic               neg_res_q, neg_rem_q, bzero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               start_ok, last_step, in_sgn, in_div;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_shift, sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   hi_res, lo_res;

  assign op_in     = muldiv_op_t'(op);
  assign in_sgn    = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign a_neg     = in_sgn & srca[WIDTH-1];
  assign b_neg     = in_sgn & srcb[WIDTH-1];
  assign a_mag     = a_neg ? (~srca + 1'b1) : srca;
  assign b_mag     = b_neg ? (~srcb + 1'b1) : srcb;
  assign start_ok  = start && !flush && (state_q != StRun);
  assign last_step = (state_q == StRun) && !flush && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun: begin
        if (flush)               state_d = StIdle;
        else if (cnt_q == '0)    state_d = StDone;
      end
      StDone:  state_d = start_ok ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    acc_step  = acc_q;
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = rem_shift[WIDTH-1:0] - m_q;
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    if (op_is_div(op_q)) begin
      if (rem_shift >= {1'b0, m_q}) acc_step = {diff, acc_q[WIDTH-2:0], 1'b1};
      else                          acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_step = {sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  muldiv_signfix #(
    .WIDTH(WIDTH)
  ) u_signfix (
    .op       (op_q),
    .raw      (acc_step),
    .neg_res  (neg_res_q),
    .neg_rem  (neg_rem_q),
    .div_zero (bzero_q),
    .hi_res   (hi_res),
    .lo_res   (lo_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= OpMultu;
      cnt_q     <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        op_q      <= op_in;
        cnt_q     <= CNTW'(WIDTH - 1);
        m_q       <= in_div ? b_mag : a_mag;
        acc_q     <= in_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        bzero_q   <= (srcb == '0);
        dbz_q     <= 1'b0;
      end else if (state_q == StRun) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - 1'b1;
      end
      // Direct writes land first; a started operation overwrites them on completion.
      if (state_q != StRun) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end else if (last_step) begin
        hi_q  <= hi_res;
        lo_q  <= lo_res;
        dbz_q <= op_is_div(op_q) & bzero_q;
      end
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] srca = '0, srcb = '0, wdata = '0;
  logic         flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Model of the architectural registers.
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dbz = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dbz   (dbz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                                 output logic rdbz);
    logic [63:0]        pu;
    logic signed [63:0] ps;
    int                 sa, sb;
    rdbz = 1'b0;
    case (o)
      2'b00: begin
        pu  = {32'b0, a} * {32'b0, b};
        rhi = pu[63:32];
        rlo = pu[31:0];
      end
      2'b01: begin
        ps  = 64'($signed(a)) * 64'($signed(b));
        rhi = ps[63:32];
        rlo = ps[31:0];
      end
      default: begin
        if (b == 0) begin
          rlo  = '1;
          rhi  = a;
          rdbz = 1'b1;
        end else if (o == 2'b10) begin
          rlo = a / b;
          rhi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rlo = 32'h8000_0000;
          rhi = '0;
        end else begin
          sa  = a;
          sb  = b;
          rlo = sa / sb;
          rhi = sa % sb;
        end
      end
    endcase
  endfunction

  // Issue a start for one cycle, then scramble the operand inputs.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    srca  = a;
    srcb  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    srca  = $urandom;
    srcb  = $urandom;
    op    = 2'($urandom_range(0, 3));
    m_dbz = 1'b0;
  endtask

  // Wait out the remaining RUN cycles, then check the completed result in the DONE cycle.
  task automatic finish(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int already);
    int n;
    n = already;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_cycles"}, 64'(n), 64'(W));
    chk({tag, "_done"}, 64'(done), 64'd1);
    ref_op(o, a, b, m_hi, m_lo, m_dbz);
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    chk({tag, "_dbz"}, 64'(dbz), 64'(m_dbz));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hi"}, 64'(hi), 64'd0);
    chk({tag, "_lo"}, 64'(lo), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_dbz"}, 64'(dbz), 64'd0);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb, w;

    #2;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Signed multiply of mixed signs.
    launch(2'b01, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy", 64'(busy), 64'd1);
    finish("mult", 2'b01, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo_const", 64'(lo), 64'hFFFF_FFF1);
    tick();
    chk("mult_done_pulse", 64'(done), 64'd0);

    launch(2'b10, 32'd100, 32'd7);
    finish("divu", 2'b10, 32'd100, 32'd7, 0);
    chk("divu_lo_const", 64'(lo), 64'd14);
    chk("divu_hi_const", 64'(hi), 64'd2);
    tick();

    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    finish("div", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
    tick();

    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    finish("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi_const", 64'(hi), 64'd0);
    tick();

    launch(2'b10, 32'd9, 32'd0);
    finish("divu_dbz", 2'b10, 32'd9, 32'd0, 0);
    chk("dbz_lo_const", 64'(lo), 64'hFFFF_FFFF);
    chk("dbz_hi_const", 64'(hi), 64'd9);
    tick();
    chk("dbz_sticky", 64'(dbz), 64'd1);

    // Direct writes in IDLE.
    hi_we = 1'b1;
    wdata = 32'h1234_5678;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h9ABC_DEF0;
    tick();
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234_5678);
    chk("mtlo", 64'(lo), 64'h9ABC_DEF0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;

    // Flush at RUN cycle 10.
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("dbz_clear", 64'(dbz), 64'd0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    tick();
    chk("flush_no_done", 64'(done), 64'd0);

    // Start and lo_we during RUN are ignored.
    ra = $urandom;
    rb = $urandom_range(1, 1000);
    launch(2'b10, ra, rb);
    repeat (2) tick();
    op    = 2'b01;
    srca  = $urandom;
    srcb  = $urandom;
    start = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    lo_we = 1'b0;
    chk("run_lo_we_ignored", 64'(lo), 64'(m_lo));
    finish("run_start_ignored", 2'b10, ra, rb, 3);

    // Back-to-back start from the DONE cycle.
    ra = $urandom;
    rb = $urandom;
    launch(2'b01, ra, rb);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done", 64'(done), 64'd0);
    finish("b2b", 2'b01, ra, rb, 0);
    tick();

    // Reset at RUN cycle 5.
    launch(2'b10, $urandom, 32'd3);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check_zero("mid_reset");
    m_hi  = '0;
    m_lo  = '0;
    m_dbz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    launch(2'b00, 32'd6, 32'd7);
    finish("post_reset", 2'b00, 32'd6, 32'd7, 0);
    chk("post_reset_lo_const", 64'(lo), 64'd42);
    chk("post_reset_hi_const", 64'(hi), 64'd0);
    tick();

    // Randomized operations with boundary operands mixed in.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        w     = $urandom;
        hi_we = 1'b1;
        wdata = w;
        tick();
        hi_we = 1'b0;
        chk("rnd_mthi", 64'(hi), 64'(w));
      end
      launch(ro, ra, rb);
      finish("rnd", ro, ra, rb, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width (even, >= 4).
REQ-002 SHALL have parameter CNTW, default $clog2(WIDTH), giving the iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a new operation.
REQ-006 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 SHALL have port srca, srcb  input  WIDTH  operands (multiplicand/dividend, multiplier/divisor).
REQ-008 SHALL have port flush  input  1  abort any in-flight operation.
REQ-009 SHALL have port hi_we, lo_we  input  1  direct HI/LO write enables (mthi/mtlo).
REQ-010 SHALL have port wdata  input  WIDTH  direct-write data.
REQ-011 SHALL have port busy  output  1  operation in progress; the pipeline stalls any HI/LO reader while it is high.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-014 SHALL have port dbz  output  1  sticky until next start: last divide had divisor zero.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-016 SHALL accept start only in IDLE or DONE with flush low; it then latches op and operand magnitudes, loads counter WIDTH-1 and enters RUN.
REQ-017 SHALL ignore start while in RUN; no state or output changes due to it.
REQ-018 SHALL perform one radix-2 step per RUN cycle: shift-add for multiply, restoring subtract-shift for divide.
REQ-019 SHALL spend exactly WIDTH cycles in RUN; on the edge ending the last step it writes HI/LO and enters DONE.
REQ-020 SHALL return from DONE to IDLE after one cycle, unless a start is accepted, in which case it enters RUN.
REQ-021 SHALL, for signed ops, operate on absolute values and fix signs at the final write: product is negative iff the operand signs differ; quotient likewise; remainder takes the dividend sign.
REQ-022 SHALL produce, for multiply, the full 2*WIDTH product: HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-023 SHALL produce, for divide, LO = quotient and HI = remainder.
REQ-024 SHALL, for divisor zero (DIVU or DIV), write LO = all ones and HI = srca, and set dbz.
REQ-025 SHALL, for DIV of the most-negative value by -1, write LO = most-negative value and HI = 0, with dbz low.
REQ-026 SHALL, on flush in RUN, return to IDLE at the next edge with HI/LO unchanged and no done pulse.
REQ-027 SHALL let flush win over start in the same cycle, so the start is dropped.
REQ-028 SHALL ignore hi_we/lo_we in RUN; in other states they write wdata at the edge.
REQ-029 SHALL, if a direct write and an accepted start occur in the same cycle, apply both; the later result overwrites HI/LO.
REQ-030 SHALL give operands no further effect once they are latched at start.

Reset
REQ-031 SHALL, while reset is low, immediately force state=IDLE, hi=0, lo=0, dbz=0, busy=0, done=0 and the counter to 0.
REQ-032 SHALL, on reset mid-operation, discard the operation; the first accepted start after release behaves as from power-up.

Structure
REQ-033 SHALL take the op encoding enum (muldiv_op_t) and FSM state enum (muldiv_state_t) from shared package muldiv_pkg.
REQ-034 SHALL place the sign-fix and special-case result logic in one combinational sub-module, muldiv_signfix; everything else is in muldiv_unit.

Verification (WIDTH=32)
REQ-035 SHALL cover: MULT srca=-3, srcb=5 -> busy for 32 cycles, done pulse, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-036 SHALL cover: DIVU 100/7 -> LO=14, HI=2, dbz=0; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9, dbz=1.
REQ-038 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF started, flush at RUN cycle 10 -> IDLE next edge, no done, HI/LO keep prior values.
REQ-039 SHALL cover: second start and lo_we during RUN -> both ignored, first result intact; start in DONE cycle -> new op runs back-to-back.
REQ-040 SHALL cover: reset asserted at RUN cycle 5 -> outputs zero immediately, and a post-release MULTU 6*7 gives LO=42, HI=0.
